unidade_controle_rodadas: RTL

Moore control unit for the multi-round memory game ("Simon" flavour). Each round it first displays the stored sequence up to the current round limit, then collects and checks the player's moves, with a per-move timeout. It advances the round counter until the last round succeeds. It drives the existing datapath: address counter E, round-limit counter L, move register R, the move timeout timer and a display interval timer.

---
 rtl/unidade_controle_pkg.sv | 39 +++
 rtl/unidade_controle_rodadas.sv | 136 +++++++++++++
 2 files changed

// File: rtl/unidade_controle_pkg.sv
// State codes shared by the round control FSM and the hex-display decoder.
// db_estado reports these raw codes.
package unidade_controle_pkg;

  localparam logic [3:0] ST_INICIAL        = 4'h0;
  localparam logic [3:0] ST_PREPARACAO     = 4'h1;
  localparam logic [3:0] ST_INICIA_RODADA  = 4'h2;
  localparam logic [3:0] ST_MOSTRA         = 4'h3;
  localparam logic [3:0] ST_APAGA          = 4'h4;
  localparam logic [3:0] ST_PROXIMO_MOSTRA = 4'h5;
  localparam logic [3:0] ST_PREPARA_JOGADA = 4'h6;
  localparam logic [3:0] ST_ESPERA         = 4'h7;
  localparam logic [3:0] ST_REGISTRA       = 4'h8;
  localparam logic [3:0] ST_COMPARACAO     = 4'h9;
  localparam logic [3:0] ST_PROXIMO        = 4'hA;
  localparam logic [3:0] ST_NOVA_RODADA    = 4'hB;
  localparam logic [3:0] ST_TIMEOUT        = 4'hC;
  localparam logic [3:0] ST_ERROU          = 4'hD;
  localparam logic [3:0] ST_ACERTOU        = 4'hF;

  typedef enum logic [3:0] {
    INICIAL        = ST_INICIAL,
    PREPARACAO     = ST_PREPARACAO,
    INICIA_RODADA  = ST_INICIA_RODADA,
    MOSTRA         = ST_MOSTRA,
    APAGA          = ST_APAGA,
    PROXIMO_MOSTRA = ST_PROXIMO_MOSTRA,
    PREPARA_JOGADA = ST_PREPARA_JOGADA,
    ESPERA         = ST_ESPERA,
    REGISTRA       = ST_REGISTRA,
    COMPARACAO     = ST_COMPARACAO,
    PROXIMO        = ST_PROXIMO,
    NOVA_RODADA    = ST_NOVA_RODADA,
    TIMEOUT        = ST_TIMEOUT,
    ERROU          = ST_ERROU,
    ACERTOU        = ST_ACERTOU
  } estado_t;

endpackage

// File: rtl/unidade_controle_rodadas.sv
// Moore control unit for the multi-round memory game: shows the sequence up to
// the current round, then collects and checks the player's moves.
module unidade_controle_rodadas
  import unidade_controle_pkg::*;
#(
  parameter bit TIMEOUT_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  input  logic       fim_timer,
  input  logic       fim_mostra,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       zera_timer,
  output logic       conta_timer,
  output logic       zera_mostra,
  output logic       conta_mostra,
  output logic       leds_mostra,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t estado_q, estado_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado_q <= INICIAL;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      INICIAL:        if (iniciar) estado_d = PREPARACAO;
      PREPARACAO:     estado_d = INICIA_RODADA;
      INICIA_RODADA:  estado_d = MOSTRA;
      MOSTRA:         if (fim_mostra) estado_d = APAGA;
      APAGA:          if (fim_mostra) estado_d = fimE ? PREPARA_JOGADA : PROXIMO_MOSTRA;
      PROXIMO_MOSTRA: estado_d = MOSTRA;
      PREPARA_JOGADA: estado_d = ESPERA;
      // a move in the same cycle as the timeout still counts
      ESPERA: begin
        if (jogada)                       estado_d = REGISTRA;
        else if (fim_timer && TIMEOUT_EN) estado_d = TIMEOUT;
      end
      REGISTRA:       estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)     estado_d = ERROU;
        else if (!fimE) estado_d = PROXIMO;
        else if (fimL)  estado_d = ACERTOU;
        else            estado_d = NOVA_RODADA;
      end
      PROXIMO:        estado_d = ESPERA;
      NOVA_RODADA:    estado_d = INICIA_RODADA;
      TIMEOUT, ERROU, ACERTOU: if (iniciar) estado_d = PREPARACAO;
      default:        estado_d = INICIAL;
    endcase
  end

  always_comb begin
    zeraE        = 1'b0;
    contaE       = 1'b0;
    zeraL        = 1'b0;
    contaL       = 1'b0;
    zeraR        = 1'b0;
    registraR    = 1'b0;
    zera_timer   = 1'b0;
    conta_timer  = 1'b0;
    zera_mostra  = 1'b0;
    conta_mostra = 1'b0;
    leds_mostra  = 1'b0;
    acertou      = 1'b0;
    errou        = 1'b0;
    timeout      = 1'b0;
    pronto       = 1'b0;
    case (estado_q)
      INICIAL, PREPARACAO: begin
        zeraE = 1'b1;
        zeraL = 1'b1;
        zeraR = 1'b1;
      end
      INICIA_RODADA: begin
        zeraE       = 1'b1;
        zera_mostra = 1'b1;
      end
      MOSTRA: begin
        leds_mostra  = 1'b1;
        conta_mostra = 1'b1;
      end
      APAGA: conta_mostra = 1'b1;
      PROXIMO_MOSTRA: begin
        contaE      = 1'b1;
        zera_mostra = 1'b1;
      end
      PREPARA_JOGADA: begin
        zeraE      = 1'b1;
        zera_timer = 1'b1;
        zeraR      = 1'b1;
      end
      ESPERA:      conta_timer = 1'b1;
      REGISTRA:    registraR   = 1'b1;
      PROXIMO: begin
        contaE     = 1'b1;
        zera_timer = 1'b1;
      end
      NOVA_RODADA: contaL = 1'b1;
      TIMEOUT: begin
        timeout = 1'b1;
        pronto  = 1'b1;
      end
      ERROU: begin
        errou  = 1'b1;
        pronto = 1'b1;
      end
      ACERTOU: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado_q;

endmodule
